decode_stage_hz: RTL and testbench
==================================

# decode_stage_hz

Parametrised instruction-decode stage with integrated ID/EX pipeline register, load-use hazard detection, branch-flush bubble insertion, a write-first register file, and saturating stall/flush event counters. It sits between the fetch stage and the execute stage of the five-stage core. It supersedes the fixed-width, always-advancing decode stage: the ID/EX register now holds on stall and inserts bubbles on hazard or flush.

## Interface
Parameters:
- XLEN, 32, datapath width for PC, register data and immediates
- NREG, 32, architectural register count; RAW = clog2(NREG) is the register-address width
- CNTW, 16, width of each event counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- InstrD  in  32  instruction from IF/ID
- PCD, PCPlus4D  in  XLEN  PC and PC+4 of InstrD
- ValidD  in  1  InstrD is a real instruction
- RegWriteW  in  1  writeback enable
- RDW  in  RAW  writeback destination
- ResultW  in  XLEN  writeback data
- FlushE  in  1  branch taken in EX; squash the instruction in D
- StallD  out  1  load-use hazard; IF and IF/ID must hold (combinational)
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE  out  1  registered control
- ALUControlE  out  4  registered ALU op
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN  registered data
- RS1_E, RS2_E, RD_E  out  RAW  registered register addresses
- StallCnt, FlushCnt  out  CNTW  saturating event counters

## Operation
- Decode: the existing control unit maps opcode/funct3/funct7 to control and ImmSrc. The immediate is sign-extended to XLEN.
- Register file: NREG x XLEN, and x0 reads as zero.
  - Write on clk when RegWriteW && RDW != 0.
  - A read of address A returns ResultW when RegWriteW && RDW == A && A != 0 (write-first bypass).
- Source use: rs1 is used by every valid instruction. rs2 is used only for opcodes 0110011, 0100011 and 1100011.
- Hazard condition: StallD = ValidD && ValidE && ResultSrcE && RegWriteE && RD_E != 0 && (RD_E == rs1 || (rs2 used && RD_E == rs2)).
- ID/EX update, highest priority first:
  1. FlushE = 1: load a bubble.
  2. StallD = 1: load a bubble. InstrD is re-presented by IF/ID next cycle.
  3. Otherwise: load the decoded fields, with ValidE = ValidD.
  4. ValidD = 0: a bubble is loaded even on the normal path.
- Bubble definition: every E output is zero, including ValidE.
- Counters:
  - StallCnt increments on each cycle with StallD = 1 && FlushE = 0.
  - FlushCnt increments on each cycle with FlushE = 1 && ValidD = 1.
  - Both saturate at 2^CNTW - 1 and do not wrap.

## Timing
- Reset: all E outputs are 0, StallCnt = FlushCnt = 0, and every register-file entry is 0. Reset is asynchronous and takes effect immediately mid-operation.
- Decode-to-E latency is 1 cycle. StallD has 0-cycle latency, derived from InstrD and the current E register.
- A load-use stall lasts exactly 1 cycle. The next cycle E holds a bubble, so the hazard clears.
- Simultaneous FlushE and StallD: the flush wins, one bubble is inserted, and StallCnt does not increment.
- Writeback and decode in the same cycle to the same register: the decoded value equals ResultW.
- A write to x0 is ignored, including on the bypass path.

## Structure
- Shared package `core_pkg`: opcode constants (OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM), ImmSrc encodings, and the ALUControl width/encodings.
- Natural sub-module: `regfile_wf` holds the register file with write-first bypass, parametrised by XLEN and NREG. The control unit and the sign extender are reused unchanged.
- Hazard logic, the bubble mux and the counters live in the top.

## Test plan
- Reset mid-stream: assert rst while ValidE = 1 → all E outputs and both counters read 0 immediately, and x5 reads 0 afterwards.
- Normal advance: `addi x1,x0,5` with ValidD = 1 → next cycle RegWriteE = 1, ALUSrcE = 1, Imm_Ext_E = 5, RD_E = 1, ValidE = 1.
- Load-use: `lw x2,0(x1)` followed by `add x3,x2,x4` → StallD = 1 for one cycle, a bubble in E (ValidE = 0), then add enters E, and StallCnt = 1.
- Flush vs stall: FlushE = 1 in the same cycle as a load-use hazard → bubble loaded, FlushCnt = 1, StallCnt unchanged.
- Write-first bypass: RegWriteW = 1, RDW = 7, ResultW = 0xDEADBEEF while decoding `add x8,x7,x0` → RD1_E = 0xDEADBEEF. The same write with RDW = 0 → RD2_E = 0.
- Saturation: CNTW = 2 with 5 consecutive stall cycles → StallCnt reads 3 and holds.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, immediate formats, ALU op encodings,
// plus the control-unit and immediate-extender functions used by decode.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  localparam int ALUCW = 4;

  typedef enum logic [ALUCW-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_ctrl_e;

  typedef struct packed {
    logic      reg_write;
    logic      alu_src;
    logic      mem_write;
    logic      result_src;
    logic      branch;
    imm_src_e  imm_src;
    alu_ctrl_e alu_ctrl;
  } ctrl_t;

  // Main decoder + ALU decoder; unknown opcodes decode to a no-op.
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t      c;
    logic [1:0] alu_op;
    c.reg_write  = 1'b0;
    c.alu_src    = 1'b0;
    c.mem_write  = 1'b0;
    c.result_src = 1'b0;
    c.branch     = 1'b0;
    c.imm_src    = IMM_I;
    c.alu_ctrl   = ALU_ADD;
    alu_op       = 2'b00;
    case (instr[6:0])
      OP_LOAD:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = 1'b1; end
      OP_STORE:  begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.imm_src = IMM_S; end
      OP_R:      begin c.reg_write = 1'b1; alu_op = 2'b10; end
      OP_BRANCH: begin c.branch = 1'b1; c.imm_src = IMM_B; alu_op = 2'b01; end
      OP_IMM:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; alu_op = 2'b10; end
      default:   ;
    endcase
    if (alu_op == 2'b01) begin
      c.alu_ctrl = ALU_SUB;
    end else if (alu_op == 2'b10) begin
      case (instr[14:12])
        3'b000:  c.alu_ctrl = (instr[6:0] == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  c.alu_ctrl = ALU_SLL;
        3'b010:  c.alu_ctrl = ALU_SLT;
        3'b100:  c.alu_ctrl = ALU_XOR;
        3'b101:  c.alu_ctrl = instr[30] ? ALU_SRA : ALU_SRL;
        3'b110:  c.alu_ctrl = ALU_OR;
        default: c.alu_ctrl = ALU_AND;
      endcase
    end
    return c;
  endfunction

  // 32-bit sign-extended immediate for the given format.
  function automatic logic [31:0] ext_imm(input logic [31:0] i, input imm_src_e src);
    case (src)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // Only R-type, store and branch read rs2.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/regfile_wf.sv
// Register file with x0 hard-wired to zero and a write-first bypass so a
// same-cycle writeback is visible to the decode read.
module regfile_wf #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [RAW-1:0]  i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [RAW-1:0]  i_ra1,
  input  logic [RAW-1:0]  i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_wa != '0);

  // Storage update; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // Read ports with write-first bypass; x0 always zero.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != '0) o_rd1 = (w_wr_en && i_wa == i_ra1) ? i_wd : r_mem[i_ra1];
    if (i_ra2 != '0) o_rd2 = (w_wr_en && i_wa == i_ra2) ? i_wd : r_mem[i_ra2];
  end

endmodule

// File: rtl/decode_stage_hz.sv
// Decode stage: control decode, register read, load-use hazard detection,
// ID/EX register with bubble insertion, and saturating stall/flush counters.
module decode_stage_hz
  import core_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int CNTW = 16,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              ValidD,
  input  logic              RegWriteW,
  input  logic [RAW-1:0]    RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic              StallD,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic              ValidE,
  output logic [ALUCW-1:0]  ALUControlE,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   Imm_Ext_E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [RAW-1:0]    RS1_E,
  output logic [RAW-1:0]    RS2_E,
  output logic [RAW-1:0]    RD_E,
  output logic [CNTW-1:0]   StallCnt,
  output logic [CNTW-1:0]   FlushCnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_t              w_ctrl;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm_ext, w_rd1, w_rd2;
  logic [RAW-1:0]     w_rs1, w_rs2, w_rd;
  logic               w_advance;

  // ID/EX register contents
  logic               r_reg_write_p1, r_alu_src_p1, r_mem_write_p1;
  logic               r_result_src_p1, r_branch_p1, r_valid_p1;
  logic [ALUCW-1:0]   r_alu_ctrl_p1;
  logic [XLEN-1:0]    r_rd1_p1, r_rd2_p1, r_imm_p1, r_pc_p1, r_pc4_p1;
  logic [RAW-1:0]     r_rs1_p1, r_rs2_p1, r_rd_p1;
  logic [CNTW-1:0]    r_stall_cnt, r_flush_cnt;

  assign w_ctrl    = decode_ctrl(InstrD);
  assign w_imm32   = ext_imm(InstrD, w_ctrl.imm_src);
  assign w_imm_ext = XLEN'(w_imm32);
  assign w_rs1     = InstrD[15 +: RAW];
  assign w_rs2     = InstrD[20 +: RAW];
  assign w_rd      = InstrD[7 +: RAW];

  regfile_wf #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_we  (RegWriteW),
    .i_wa  (RDW),
    .i_wd  (ResultW),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  // Load in E whose destination is read by the instruction in D.
  assign StallD = ValidD && r_valid_p1 && r_result_src_p1 && r_reg_write_p1 &&
                  (r_rd_p1 != '0) &&
                  ((r_rd_p1 == w_rs1) || (uses_rs2(InstrD[6:0]) && r_rd_p1 == w_rs2));

  // Flush, stall and invalid D all load an all-zero bubble.
  assign w_advance = !FlushE && !StallD && ValidD;

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !w_advance) begin
      r_reg_write_p1  <= 1'b0;
      r_alu_src_p1    <= 1'b0;
      r_mem_write_p1  <= 1'b0;
      r_result_src_p1 <= 1'b0;
      r_branch_p1     <= 1'b0;
      r_valid_p1      <= 1'b0;
      r_alu_ctrl_p1   <= '0;
      r_rd1_p1        <= '0;
      r_rd2_p1        <= '0;
      r_imm_p1        <= '0;
      r_pc_p1         <= '0;
      r_pc4_p1        <= '0;
      r_rs1_p1        <= '0;
      r_rs2_p1        <= '0;
      r_rd_p1         <= '0;
    end else begin
      r_reg_write_p1  <= w_ctrl.reg_write;
      r_alu_src_p1    <= w_ctrl.alu_src;
      r_mem_write_p1  <= w_ctrl.mem_write;
      r_result_src_p1 <= w_ctrl.result_src;
      r_branch_p1     <= w_ctrl.branch;
      r_valid_p1      <= 1'b1;
      r_alu_ctrl_p1   <= w_ctrl.alu_ctrl;
      r_rd1_p1        <= w_rd1;
      r_rd2_p1        <= w_rd2;
      r_imm_p1        <= w_imm_ext;
      r_pc_p1         <= PCD;
      r_pc4_p1        <= PCPlus4D;
      r_rs1_p1        <= w_rs1;
      r_rs2_p1        <= w_rs2;
      r_rd_p1         <= w_rd;
    end
  end

  // Saturating event counters; a flush masks a coincident stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && !FlushE) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (FlushE && ValidD)  r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign RegWriteE   = r_reg_write_p1;
  assign ALUSrcE     = r_alu_src_p1;
  assign MemWriteE   = r_mem_write_p1;
  assign ResultSrcE  = r_result_src_p1;
  assign BranchE     = r_branch_p1;
  assign ValidE      = r_valid_p1;
  assign ALUControlE = r_alu_ctrl_p1;
  assign RD1_E       = r_rd1_p1;
  assign RD2_E       = r_rd2_p1;
  assign Imm_Ext_E   = r_imm_p1;
  assign PCE         = r_pc_p1;
  assign PCPlus4E    = r_pc4_p1;
  assign RS1_E       = r_rs1_p1;
  assign RS2_E       = r_rs2_p1;
  assign RD_E        = r_rd_p1;
  assign StallCnt    = r_stall_cnt;
  assign FlushCnt    = r_flush_cnt;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz with hand-computed expectations.
module tb_decode_stage_hz;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int CNTW = 2;
  localparam int RAW  = 5;

  localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_LW_X2_X1    = 32'h0000_A103; // lw   x2,0(x1)
  localparam logic [31:0] I_ADD_X3_X2   = 32'h0041_01B3; // add  x3,x2,x4
  localparam logic [31:0] I_ADD_X8_X7   = 32'h0003_8433; // add  x8,x7,x0
  localparam logic [31:0] I_BEQ_X1_X2   = 32'h0020_8463; // beq  x1,x2,+8
  localparam logic [31:0] I_SW_X2_M4    = 32'hFE20_AE23; // sw   x2,-4(x1)
  localparam logic [31:0] I_ADDI_X6_X5  = 32'h0002_8313; // addi x6,x5,0

  logic              clk;
  logic              rst;
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD, PCPlus4D;
  logic              ValidD;
  logic              RegWriteW;
  logic [RAW-1:0]    RDW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;
  logic              StallD;
  logic              RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE;
  logic [3:0]        ALUControlE;
  logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [RAW-1:0]    RS1_E, RS2_E, RD_E;
  logic [CNTW-1:0]   StallCnt, FlushCnt;

  int n_checks = 0;
  int n_errors = 0;

  decode_stage_hz #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD),
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .ResultW     (ResultW),
    .FlushE      (FlushE),
    .StallD      (StallD),
    .RegWriteE   (RegWriteE),
    .ALUSrcE     (ALUSrcE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .ValidE      (ValidE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .RS1_E       (RS1_E),
    .RS2_E       (RS2_E),
    .RD_E        (RD_E),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0; ValidD = 1'b0;
    RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0;
    tick();
    check("rst_validE",   32'(ValidE),    32'd0);
    check("rst_regwrE",   32'(RegWriteE), 32'd0);
    check("rst_stallcnt", 32'(StallCnt),  32'd0);
    check("rst_flushcnt", 32'(FlushCnt),  32'd0);
    rst = 1'b0;

    // Write x5 with no instruction in D
    RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'h1234_5678;
    tick();
    RegWriteW = 1'b0;

    // Normal advance
    InstrD = I_ADDI_X1_5; ValidD = 1'b1; PCD = 32'h100; PCPlus4D = 32'h104;
    tick();
    check("addi_regwr",  32'(RegWriteE),   32'd1);
    check("addi_alusrc", 32'(ALUSrcE),     32'd1);
    check("addi_imm",    Imm_Ext_E,        32'd5);
    check("addi_rd",     32'(RD_E),        32'd1);
    check("addi_valid",  32'(ValidE),      32'd1);
    check("addi_ressrc", 32'(ResultSrcE),  32'd0);
    check("addi_pc",     PCE,              32'h100);
    check("addi_pc4",    PCPlus4E,         32'h104);

    // Load-use
    InstrD = I_LW_X2_X1;
    tick();
    check("lw_ressrc", 32'(ResultSrcE), 32'd1);
    check("lw_rd",     32'(RD_E),       32'd2);
    InstrD = I_ADD_X3_X2;
    #1;
    check("lu_stall", 32'(StallD), 32'd1);
    tick();
    check("lu_bubble",   32'(ValidE),   32'd0);
    check("lu_bub_rd",   32'(RD_E),     32'd0);
    check("lu_stallcnt", 32'(StallCnt), 32'd1);
    #1;
    check("lu_stall_clr", 32'(StallD), 32'd0);
    tick();
    check("lu_add_valid", 32'(ValidE),      32'd1);
    check("lu_add_rd",    32'(RD_E),        32'd3);
    check("lu_add_rs1",   32'(RS1_E),       32'd2);
    check("lu_add_rs2",   32'(RS2_E),       32'd4);
    check("lu_add_alu",   32'(ALUControlE), 32'd0);
    check("lu_stallcnt2", 32'(StallCnt),    32'd1);

    // Flush wins over a coincident stall
    InstrD = I_LW_X2_X1;
    tick();
    InstrD = I_ADD_X3_X2; FlushE = 1'b1;
    #1;
    check("fl_stall", 32'(StallD), 32'd1);
    tick();
    FlushE = 1'b0;
    check("fl_bubble",   32'(ValidE),   32'd0);
    check("fl_flushcnt", 32'(FlushCnt), 32'd1);
    check("fl_stallcnt", 32'(StallCnt), 32'd1);

    // Invalid D loads a bubble
    InstrD = I_ADDI_X1_5; ValidD = 1'b0;
    tick();
    check("inv_valid", 32'(ValidE),    32'd0);
    check("inv_regwr", 32'(RegWriteE), 32'd0);
    check("inv_imm",   Imm_Ext_E,      32'd0);
    ValidD = 1'b1;

    // Write-first bypass, then x0 write ignored
    InstrD = I_ADD_X8_X7; RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'hDEAD_BEEF;
    tick();
    check("byp_rd1", RD1_E,        32'hDEAD_BEEF);
    check("byp_rd2", RD2_E,        32'd0);
    check("byp_rd",  32'(RD_E),    32'd8);
    RDW = 5'd0; ResultW = 32'hCAFE_F00D;
    tick();
    check("x0_rd2", RD2_E, 32'd0);
    check("x0_rd1", RD1_E, 32'hDEAD_BEEF);
    RegWriteW = 1'b0;

    // Branch and store decode
    InstrD = I_BEQ_X1_X2;
    tick();
    check("beq_branch", 32'(BranchE),     32'd1);
    check("beq_imm",    Imm_Ext_E,        32'd8);
    check("beq_alu",    32'(ALUControlE), 32'd1);
    check("beq_regwr",  32'(RegWriteE),   32'd0);
    InstrD = I_SW_X2_M4;
    tick();
    check("sw_memwr", 32'(MemWriteE), 32'd1);
    check("sw_imm",   Imm_Ext_E,      32'hFFFF_FFFC);
    check("sw_rd2",   RD2_E,          32'd0);

    // Asynchronous reset mid-stream
    InstrD = I_ADDI_X6_X5;
    tick();
    check("x5_before", RD1_E,          32'h1234_5678);
    check("x5_valid",  32'(ValidE),    32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid",    32'(ValidE),   32'd0);
    check("arst_rd1",      RD1_E,         32'd0);
    check("arst_stallcnt", 32'(StallCnt), 32'd0);
    check("arst_flushcnt", 32'(FlushCnt), 32'd0);
    rst = 1'b0;
    tick();
    check("x5_after",  RD1_E,       32'd0);
    check("x5_validE", 32'(ValidE), 32'd1);

    // Counter saturation over five load-use events
    for (int i = 0; i < 5; i++) begin
      InstrD = I_LW_X2_X1;
      tick();
      InstrD = I_ADD_X3_X2;
      tick();
      tick();
      check($sformatf("sat_%0d", i), 32'(StallCnt), (i < 2) ? 32'(i + 1) : 32'd3);
    end
    tick();
    check("sat_hold", 32'(StallCnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
